// File: rtl/cnn_stream_loader.sv
// Byte-stream front-end for cnn_top.
// It splits a header-prefixed byte stream across the conv data, conv weight
// and dense weight BRAM write ports. When the header asks for a run, it pulses
// start, waits for done (bounded by TIMEOUT), and returns the class or an
// error flag on a valid/ready result port.
module cnn_stream_loader #(
    parameter int DATA_W       = 8,
    parameter int CONV_ADDR_W  = 4,
    parameter int DENSE_ADDR_W = 5,
    parameter int N_INPUT      = 8,
    parameter int N_TAPS       = 3,
    parameter int N_FEAT       = 6,
    parameter int N_CLASS      = 3,
    parameter int TIMEOUT      = 1024
) (
    input  logic                    clk,
    input  logic                    rst,
    // byte stream in
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [DATA_W-1:0]       s_data,
    // conv input BRAM write port
    output logic                    data_bram_wen,
    output logic [CONV_ADDR_W-1:0]  data_bram_addr,
    output logic [DATA_W-1:0]       data_bram_din,
    // conv kernel BRAM write port
    output logic                    weight_bram_wen,
    output logic [CONV_ADDR_W-1:0]  weight_bram_addr,
    output logic [DATA_W-1:0]       weight_bram_din,
    // dense weight BRAM write port
    output logic                    dense_w_bram_wen,
    output logic [DENSE_ADDR_W-1:0] dense_w_bram_addr,
    output logic [DATA_W-1:0]       dense_w_bram_din,
    // cnn_top control
    output logic                    start,
    input  logic                    done,
    input  logic [1:0]              class_in,
    // result port
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [1:0]              res_class,
    output logic                    res_err,
    output logic                    busy
);

    typedef enum logic [2:0] {
        IDLE, LD_DATA, LD_CW, LD_DW, START, WAIT_DONE, CAPTURE, RESULT
    } state_t;

    // The load counter is shared by all load states, so it takes the widest address.
    localparam int CNT_W = (DENSE_ADDR_W > CONV_ADDR_W) ? DENSE_ADDR_W : CONV_ADDR_W;
    localparam int TMO_W = $clog2(TIMEOUT);

    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(N_INPUT - 1);
    localparam logic [CNT_W-1:0] CW_LAST   = CNT_W'(N_TAPS - 1);
    localparam logic [CNT_W-1:0] DW_LAST   = CNT_W'(N_CLASS * N_FEAT - 1);
    localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT - 1);

    state_t                  state_q;
    logic [3:0]              hdr_q;      // {run, load_dw, load_cw, load_data}
    logic [CNT_W-1:0]        ld_cnt_q;
    logic [TMO_W-1:0]        wait_cnt_q;
    logic                    s_ready_q;
    logic                    data_wen_q, cw_wen_q, dw_wen_q;
    logic [CONV_ADDR_W-1:0]  data_addr_q, cw_addr_q;
    logic [DENSE_ADDR_W-1:0] dw_addr_q;
    logic [DATA_W-1:0]       data_din_q, cw_din_q, dw_din_q;
    logic                    start_q;
    logic                    res_valid_q;
    logic [1:0]              res_class_q;
    logic                    res_err_q;
    logic                    xfer;

    assign xfer = s_valid & s_ready_q;

    // Picks the next enabled load stage after 'cur'. If no load stage remains,
    // it picks START when run is set and IDLE otherwise.
    function automatic state_t next_stage(input state_t cur, input logic [3:0] f);
        state_t nxt;
        if ((cur == IDLE) && f[0])
            nxt = LD_DATA;
        else if (((cur == IDLE) || (cur == LD_DATA)) && f[1])
            nxt = LD_CW;
        else if (((cur == IDLE) || (cur == LD_DATA) || (cur == LD_CW)) && f[2])
            nxt = LD_DW;
        else if (f[3])
            nxt = START;
        else
            nxt = IDLE;
        return nxt;
    endfunction

    // States in which the loader will take a stream byte.
    function automatic logic accepts(input state_t s);
        return (s == IDLE) || (s == LD_DATA) || (s == LD_CW) || (s == LD_DW);
    endfunction

    // Control FSM, load and timeout counters, and every registered output.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            hdr_q       <= '0;
            ld_cnt_q    <= '0;
            wait_cnt_q  <= '0;
            s_ready_q   <= 1'b0;
            data_wen_q  <= 1'b0;
            cw_wen_q    <= 1'b0;
            dw_wen_q    <= 1'b0;
            data_addr_q <= '0;
            cw_addr_q   <= '0;
            dw_addr_q   <= '0;
            data_din_q  <= '0;
            cw_din_q    <= '0;
            dw_din_q    <= '0;
            start_q     <= 1'b0;
            res_valid_q <= 1'b0;
            res_class_q <= '0;
            res_err_q   <= 1'b0;
        end else begin
            data_wen_q <= 1'b0;
            cw_wen_q   <= 1'b0;
            dw_wen_q   <= 1'b0;
            start_q    <= 1'b0;
            case (state_q)
                IDLE: begin
                    s_ready_q <= 1'b1;
                    if (xfer) begin
                        hdr_q     <= s_data[3:0];
                        state_q   <= next_stage(IDLE, s_data[3:0]);
                        s_ready_q <= accepts(next_stage(IDLE, s_data[3:0]));
                    end
                end
                LD_DATA: if (xfer) begin
                    data_wen_q  <= 1'b1;
                    data_addr_q <= ld_cnt_q[CONV_ADDR_W-1:0];
                    data_din_q  <= s_data;
                    if (ld_cnt_q == DATA_LAST) begin
                        ld_cnt_q  <= '0;
                        state_q   <= next_stage(LD_DATA, hdr_q);
                        s_ready_q <= accepts(next_stage(LD_DATA, hdr_q));
                    end else begin
                        ld_cnt_q <= ld_cnt_q + CNT_W'(1);
                    end
                end
                LD_CW: if (xfer) begin
                    cw_wen_q  <= 1'b1;
                    cw_addr_q <= ld_cnt_q[CONV_ADDR_W-1:0];
                    cw_din_q  <= s_data;
                    if (ld_cnt_q == CW_LAST) begin
                        ld_cnt_q  <= '0;
                        state_q   <= next_stage(LD_CW, hdr_q);
                        s_ready_q <= accepts(next_stage(LD_CW, hdr_q));
                    end else begin
                        ld_cnt_q <= ld_cnt_q + CNT_W'(1);
                    end
                end
                LD_DW: if (xfer) begin
                    // The counter runs class-major, so it is already c*N_FEAT + f.
                    dw_wen_q  <= 1'b1;
                    dw_addr_q <= ld_cnt_q[DENSE_ADDR_W-1:0];
                    dw_din_q  <= s_data;
                    if (ld_cnt_q == DW_LAST) begin
                        ld_cnt_q  <= '0;
                        state_q   <= next_stage(LD_DW, hdr_q);
                        s_ready_q <= accepts(next_stage(LD_DW, hdr_q));
                    end else begin
                        ld_cnt_q <= ld_cnt_q + CNT_W'(1);
                    end
                end
                START: begin
                    // The final write is already on the BRAM port, so start
                    // reaches cnn_top strictly after it.
                    start_q    <= 1'b1;
                    wait_cnt_q <= '0;
                    state_q    <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (done) begin
                        wait_cnt_q <= '0;
                        state_q    <= CAPTURE;
                    end else if (wait_cnt_q == TMO_LAST) begin
                        wait_cnt_q  <= '0;
                        res_err_q   <= 1'b1;
                        res_class_q <= '0;
                        res_valid_q <= 1'b1;
                        state_q     <= RESULT;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + TMO_W'(1);
                    end
                end
                CAPTURE: begin
                    // class_in is sampled one cycle after done so that it has settled.
                    res_class_q <= class_in;
                    res_err_q   <= 1'b0;
                    res_valid_q <= 1'b1;
                    state_q     <= RESULT;
                end
                RESULT: if (res_ready) begin
                    res_valid_q <= 1'b0;
                    s_ready_q   <= 1'b1;
                    state_q     <= IDLE;
                end
                default: begin
                    s_ready_q <= 1'b1;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

    assign s_ready           = s_ready_q;
    assign data_bram_wen     = data_wen_q;
    assign data_bram_addr    = data_addr_q;
    assign data_bram_din     = data_din_q;
    assign weight_bram_wen   = cw_wen_q;
    assign weight_bram_addr  = cw_addr_q;
    assign weight_bram_din   = cw_din_q;
    assign dense_w_bram_wen  = dw_wen_q;
    assign dense_w_bram_addr = dw_addr_q;
    assign dense_w_bram_din  = dw_din_q;
    assign start             = start_q;
    assign res_valid         = res_valid_q;
    assign res_class         = res_class_q;
    assign res_err           = res_err_q;
    assign busy              = (state_q != IDLE);

endmodule

// File: tb/tb_cnn_stream_loader.sv
// Bench for cnn_stream_loader.
// A table of frames is driven through the stream port. Expected BRAM writes
// are queued as each frame is built and are popped by a write monitor. A small
// cnn_top stand-in answers start with done/class_in. Hand-written sequences
// cover reset state and a reset that lands in the middle of a load.
module tb_cnn_stream_loader;

    localparam int TIMEOUT = 1024;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       s_valid = 1'b0;
    logic       s_ready;
    logic [7:0] s_data = 8'h00;
    logic       data_bram_wen, weight_bram_wen, dense_w_bram_wen;
    logic [3:0] data_bram_addr, weight_bram_addr;
    logic [4:0] dense_w_bram_addr;
    logic [7:0] data_bram_din, weight_bram_din, dense_w_bram_din;
    logic       start;
    logic       done = 1'b0;
    logic [1:0] class_in = 2'd3;
    logic       res_valid;
    logic       res_ready = 1'b0;
    logic [1:0] res_class;
    logic       res_err;
    logic       busy;

    cnn_stream_loader #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .data_bram_wen(data_bram_wen), .data_bram_addr(data_bram_addr), .data_bram_din(data_bram_din),
        .weight_bram_wen(weight_bram_wen), .weight_bram_addr(weight_bram_addr), .weight_bram_din(weight_bram_din),
        .dense_w_bram_wen(dense_w_bram_wen), .dense_w_bram_addr(dense_w_bram_addr), .dense_w_bram_din(dense_w_bram_din),
        .start(start), .done(done), .class_in(class_in),
        .res_valid(res_valid), .res_ready(res_ready), .res_class(res_class), .res_err(res_err),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;
    int start_cnt = 0;

    typedef struct packed {
        logic [1:0] port;   // 0 data, 1 conv weight, 2 dense weight
        logic [4:0] addr;
        logic [7:0] din;
    } wr_t;
    wr_t wq[$];

    typedef struct {
        logic [7:0] hdr;
        int         hot;        // class whose dense rows carry weight 5
        bit         gaps;
        int         done_dly;   // < 0: done never asserted
        int         ready_dly;
        logic [1:0] exp_class;
        logic       exp_err;
    } vec_t;
    vec_t vt[10];

    logic [7:0] data_pat[8] = '{8'd1, 8'd0, 8'd1, 8'd0, 8'd1, 8'd0, 8'd1, 8'd0};
    logic [7:0] cw_pat[3]   = '{8'd1, 8'd2, 8'd1};

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endfunction

    // Write monitor: each write must follow a transfer and match the queue head.
    bit prev_xfer = 1'b0;
    always @(negedge clk) begin
        int  nw;
        wr_t got_w;
        wr_t exp_w;
        nw = int'(data_bram_wen) + int'(weight_bram_wen) + int'(dense_w_bram_wen);
        if (nw != 0) begin
            check("wen_after_xfer", {30'd0, nw == 1, prev_xfer}, 32'd3);
            if (data_bram_wen)        got_w = {2'd0, 1'b0, data_bram_addr, data_bram_din};
            else if (weight_bram_wen) got_w = {2'd1, 1'b0, weight_bram_addr, weight_bram_din};
            else                      got_w = {2'd2, dense_w_bram_addr, dense_w_bram_din};
            $display("wr port=%0d addr=%0d din=%0d", got_w.port, got_w.addr, got_w.din);
            check("write_expected", 32'(wq.size() > 0), 32'd1);
            if (wq.size() > 0) begin
                exp_w = wq.pop_front();
                check("write", 32'(got_w), 32'(exp_w));
            end
        end
        prev_xfer = s_valid && s_ready;
        if (start) begin
            start_cnt++;
            check("start_after_writes", 32'(wq.size()), 32'd0);
        end
    end

    // Offer one byte and hold it until it transfers. With gaps set, random idle
    // cycles (with junk data) are inserted first.
    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int guard;
        guard = 0;
        if (gaps) begin
            while (($urandom_range(1, 0) == 1) && (guard < 8)) begin
                s_valid = 1'b0;
                s_data  = 8'($urandom);
                @(posedge clk); #1;
                guard++;
            end
        end
        s_valid = 1'b1;
        s_data  = b;
        guard   = 0;
        @(negedge clk);
        while (!s_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!s_ready) check("s_ready_wait", 32'(s_ready), 32'd1);
        @(posedge clk); #1;
        s_valid = 1'b0;
        s_data  = 8'($urandom);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        logic [7:0] fb[$];
        logic [7:0] w;
        int  sc0, start_cyc, done_cyc, res_cyc;
        bit  got;
        done_cyc = 0;
        @(posedge clk); #1;
        fb.push_back(v.hdr);
        if (v.hdr[0]) for (int i = 0; i < 8; i++) begin
            fb.push_back(data_pat[i]);
            wq.push_back({2'd0, 5'(i), data_pat[i]});
        end
        if (v.hdr[1]) for (int i = 0; i < 3; i++) begin
            fb.push_back(cw_pat[i]);
            wq.push_back({2'd1, 5'(i), cw_pat[i]});
        end
        if (v.hdr[2]) for (int i = 0; i < 18; i++) begin
            w = ((i / 6) == v.hot) ? 8'd5 : 8'd1;
            fb.push_back(w);
            wq.push_back({2'd2, 5'(i), w});
        end
        class_in = 2'd3;
        sc0 = start_cnt;
        foreach (fb[i]) send_byte(fb[i], v.gaps);

        if (v.hdr[3]) begin
            got = 1'b0;
            for (int k = 0; k < 60 && !got; k++) begin
                @(negedge clk);
                if (start) got = 1'b1;
            end
            check("start_seen", 32'(got), 32'd1);
            start_cyc = cyc;
            if (v.done_dly >= 0) begin
                @(posedge clk); #1;
                repeat (v.done_dly) begin @(posedge clk); #1; end
                done     = 1'b1;
                class_in = 2'(v.hot);
                done_cyc = cyc;
                @(posedge clk); #1;
                done = 1'b0;
            end
            got = 1'b0;
            for (int k = 0; k < TIMEOUT + 100 && !got; k++) begin
                @(negedge clk);
                if (res_valid) got = 1'b1;
            end
            check("res_valid_seen", 32'(got), 32'd1);
            res_cyc = cyc;
            if (v.done_dly >= 0) check("done_to_res_latency", 32'(res_cyc - done_cyc), 32'd2);
            else                 check("timeout_latency", 32'(res_cyc - start_cyc), 32'(TIMEOUT));
            check("res_class", 32'(res_class), 32'(v.exp_class));
            check("res_err", 32'(res_err), 32'(v.exp_err));
            check("start_count", 32'(start_cnt - sc0), 32'd1);
            $display("vec %0d hdr=0x%02h class=%0d err=%0d cycle=%0d", idx, v.hdr, res_class, res_err, res_cyc);
            for (int k = 0; k < v.ready_dly; k++) begin
                @(negedge clk);
                check("result_hold", {27'd0, res_valid, res_class, res_err, busy, s_ready},
                      {27'd0, 1'b1, v.exp_class, v.exp_err, 1'b1, 1'b0});
            end
            res_ready = 1'b1;
            @(posedge clk); #1;
            res_ready = 1'b0;
            @(negedge clk);
            check("result_release", {29'd0, res_valid, busy, s_ready}, 32'd1);
        end else begin
            @(negedge clk);
            check("idle_after_load", {29'd0, busy, s_ready, res_valid}, 32'd2);
            repeat (5) @(negedge clk);
            check("no_start", 32'(start_cnt - sc0), 32'd0);
            $display("vec %0d hdr=0x%02h load only, no run", idx, v.hdr);
        end
        check("writes_drained", 32'(wq.size()), 32'd0);
    endtask

    // A reset four bytes into LD_DATA must abort the load: no further writes and no start.
    task automatic reset_mid_load();
        int sc0;
        @(posedge clk); #1;
        sc0 = start_cnt;
        send_byte(8'h0F, 1'b0);
        for (int i = 0; i < 4; i++) begin
            wq.push_back({2'd0, 5'(i), data_pat[i]});
            send_byte(data_pat[i], 1'b0);
        end
        rst     = 1'b1;
        s_valid = 1'b1;
        s_data  = 8'hAA;
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_mid_outputs", {26'd0, data_bram_wen, weight_bram_wen, dense_w_bram_wen, busy, s_ready, start}, 32'd0);
        @(posedge clk); #1;
        rst     = 1'b0;
        s_valid = 1'b0;
        repeat (20) @(negedge clk);
        check("rst_mid_no_start", 32'(start_cnt - sc0), 32'd0);
        check("rst_mid_no_result", {30'd0, res_valid, busy}, 32'd0);
        check("rst_mid_writes", 32'(wq.size()), 32'd0);
        $display("reset mid-load: 4 writes then abort, cycle=%0d", cyc);
    endtask

    initial begin
        //        hdr    hot gaps dly rdy  class err
        vt[0] = '{8'h0F, 0, 1'b0, 3,  0,  2'd0, 1'b0};
        vt[1] = '{8'h0F, 1, 1'b0, 0,  0,  2'd1, 1'b0};
        vt[2] = '{8'h0F, 2, 1'b0, 7,  0,  2'd2, 1'b0};
        vt[3] = '{8'h0C, 1, 1'b0, 2,  0,  2'd1, 1'b0};
        vt[4] = '{8'h0F, 0, 1'b1, 1,  0,  2'd0, 1'b0};
        vt[5] = '{8'h0F, 2, 1'b0, 4,  10, 2'd2, 1'b0};
        vt[6] = '{8'h0F, 1, 1'b0, -1, 3,  2'd0, 1'b1};
        vt[7] = '{8'h07, 0, 1'b0, 0,  0,  2'd0, 1'b0};
        vt[8] = '{8'hF8, 2, 1'b0, 5,  0,  2'd2, 1'b0};
        vt[9] = '{8'h0A, 1, 1'b1, 2,  2,  2'd1, 1'b0};

        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ctrl", {23'd0, s_ready, busy, start, res_valid, res_err, res_class,
                           data_bram_wen, weight_bram_wen, dense_w_bram_wen}, 32'd0);
        check("rst_addr", {19'd0, data_bram_addr, weight_bram_addr, dense_w_bram_addr}, 32'd0);
        check("rst_din", {8'd0, data_bram_din, weight_bram_din, dense_w_bram_din}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < 10; i++) run_vec(vt[i], i);
        reset_mid_load();
        run_vec(vt[0], 10);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

endmodule
